// File: rtl/mod_counter_n.sv
// Parametrised modulo-N up/down counter with parallel load, wrap/saturate mode,
// a combinational terminal-count output for cascading and a sticky overflow flag.
module mod_counter_n #(
  parameter int unsigned      WIDTH     = 4,
  parameter longint unsigned  MOD       = 16,
  parameter bit               SATURATE  = 1'b0,
  parameter longint unsigned  RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             upper,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] HALF_VAL = WIDTH'(MOD / 2);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_term;
  logic             boundary;

  // The boundary event fires even when saturating, so a held count still flags it.
  always_comb begin
    at_term  = up ? (q_q == MAX_VAL) : (q_q == '0);
    boundary = en & ~load & ~reset & at_term;
  end

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (load) begin
      q_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (at_term) begin
        if (!SATURATE) begin
          q_d = up ? '0 : MAX_VAL;
        end
      end else begin
        q_d = up ? (q_q + 1'b1) : (q_q - 1'b1);
      end
    end
    if (boundary) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= INIT_VAL;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q     = q_q;
  assign upper = (q_q >= HALF_VAL);
  assign tc    = boundary;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter_n.sv
// Self-checking bench for mod_counter_n: three differently parametrised instances share
// one directed+random stimulus stream against a behavioural model, plus a two-stage cascade.
module tb_mod_counter_n;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] loadVal;
  logic       ovfClr;

  logic [3:0] qOut     [3];
  logic       upperOut [3];
  logic       tcOut    [3];
  logic       ovfOut   [3];

  logic       cascReset;
  logic       cascEn;
  logic [3:0] cq1, cq2;
  logic       cUpper1, cUpper2, cTc1, cTc2, cOvf1, cOvf2;

  int passCount;
  int checkCount;

  // Reference model state and the parameters of each instance.
  int modelQ   [3];
  bit modelOvf [3];
  int modV     [3] = '{16, 10, 10};
  bit satV     [3] = '{1'b0, 1'b0, 1'b1};
  int rstV     [3] = '{0, 0, 3};

  mod_counter_n dut0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(loadVal),
    .ovf_clr(ovfClr), .Q(qOut[0]), .upper(upperOut[0]), .tc(tcOut[0]), .ovf(ovfOut[0])
  );

  mod_counter_n #(.WIDTH(4), .MOD(10), .SATURATE(1'b0), .RESET_VAL(0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(loadVal),
    .ovf_clr(ovfClr), .Q(qOut[1]), .upper(upperOut[1]), .tc(tcOut[1]), .ovf(ovfOut[1])
  );

  mod_counter_n #(.WIDTH(4), .MOD(10), .SATURATE(1'b1), .RESET_VAL(3)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(loadVal),
    .ovf_clr(ovfClr), .Q(qOut[2]), .upper(upperOut[2]), .tc(tcOut[2]), .ovf(ovfOut[2])
  );

  mod_counter_n cascLo (
    .clk(clk), .reset(cascReset), .en(cascEn), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .ovf_clr(1'b0), .Q(cq1), .upper(cUpper1), .tc(cTc1), .ovf(cOvf1)
  );

  mod_counter_n cascHi (
    .clk(clk), .reset(cascReset), .en(cTc1), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .ovf_clr(1'b0), .Q(cq2), .upper(cUpper2), .tc(cTc2), .ovf(cOvf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Terminal count as the model sees it, from the current state and inputs.
  function automatic bit modelTc(int i);
    bit atEnd;
    atEnd = up ? (modelQ[i] == modV[i] - 1) : (modelQ[i] == 0);
    return !reset && !load && en && atEnd;
  endfunction

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("dut%0d.Q", i), 32'(qOut[i]), 32'(modelQ[i]));
      checkVal($sformatf("dut%0d.upper", i), 32'(upperOut[i]), 32'(modelQ[i] >= modV[i] / 2));
      checkVal($sformatf("dut%0d.tc", i), 32'(tcOut[i]), 32'(modelTc(i)));
      checkVal($sformatf("dut%0d.ovf", i), 32'(ovfOut[i]), 32'(modelOvf[i]));
    end
  endtask

  task automatic modelStep();
    bit ev;
    for (int i = 0; i < 3; i++) begin
      ev = modelTc(i);
      if (reset) begin
        modelQ[i]   = rstV[i];
        modelOvf[i] = 1'b0;
      end else begin
        if (load) begin
          modelQ[i] = (int'(loadVal) < modV[i]) ? int'(loadVal) : modV[i] - 1;
        end else if (en) begin
          if (!(satV[i] && ev)) begin
            modelQ[i] = up ? (modelQ[i] + 1) % modV[i] : (modelQ[i] + modV[i] - 1) % modV[i];
          end
        end
        if (ev) modelOvf[i] = 1'b1;
        else if (ovfClr) modelOvf[i] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l,
                               input int lv, input bit c);
    reset   = r;
    en      = e;
    up      = u;
    load    = l;
    loadVal = 4'(lv);
    ovfClr  = c;
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    int cycles;
    passCount  = 0;
    checkCount = 0;
    cascReset  = 1'b1;
    cascEn     = 1'b0;
    reset      = 1'b1;
    en         = 1'b0;
    up         = 1'b1;
    load       = 1'b0;
    loadVal    = 4'd0;
    ovfClr     = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      modelQ[i]   = rstV[i];
      modelOvf[i] = 1'b0;
    end
    @(negedge clk);

    // Reset held: en and load must be ignored.
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 5, 0);
    // Plain up count across the wrap.
    for (int k = 0; k < 20; k++) applyStimulus(0, 1, 1, 0, 0, 0);
    // Down count from zero.
    applyStimulus(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) applyStimulus(0, 1, 0, 0, 0, 0);
    // Load 8 then count into the top; clear ovf while the event is still active.
    applyStimulus(0, 0, 1, 1, 8, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    // Out-of-range load clamps, load beats en.
    applyStimulus(0, 0, 1, 1, 13, 0);
    applyStimulus(0, 1, 1, 1, 9, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    // Mid-count reset with a pending load.
    applyStimulus(0, 0, 1, 1, 7, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 2, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Randomised phase.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75, 1'($urandom),
                    $urandom_range(0, 99) < 10, $urandom_range(0, 15),
                    $urandom_range(0, 99) < 10);
    end

    // Cascade: combined value tracks the cycle count modulo 256.
    cascReset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cascReset = 1'b0;
    cascEn    = 1'b1;
    cycles    = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      checkVal("cascade", 32'({cq2, cq1}), 32'(cycles % 256));
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
